// File: rtl/dsa_pkg.sv
// Shared types and Q8.8 helpers for the bilinear resize scan path.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package dsa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    EMIT,
    FINISH
  } scan_state_t;

  localparam int unsigned FRAC_BITS = 8;
  localparam logic [7:0]  FRAC_MAX  = 8'hFF;

  // Saturating add of a Q8.8 step into a 24-bit Q16.8 accumulator (never wraps).
  function automatic logic [23:0] acc_add(input logic [23:0] acc, input logic [15:0] step);
    logic [24:0] sum;
    sum = {1'b0, acc} + {9'd0, step};
    return sum[24] ? 24'hFF_FFFF : sum[23:0];
  endfunction

  // Edge clamp: keep the +1 neighbour inside the source image.
  function automatic logic [23:0] clamp_coord(input logic [23:0] acc, input logic [15:0] src_dim);
    logic [15:0] last_idx;
    last_idx = src_dim - 16'd1;
    if (acc[23:FRAC_BITS] >= last_idx) begin
      return {src_dim - 16'd2, FRAC_MAX};
    end
    return acc;
  endfunction

endpackage

// File: rtl/dsa_coord_gen.sv
// Destination raster walker: dst_x/dst_y counters, Q16.8 source accumulators, clamp, address.
// Latency: counters update on the edge after advance/clear; coordinate and address outputs are combinational from state.
// Backpressure: none; advances only when the controller pulses advance.
module dsa_coord_gen
  import dsa_pkg::*;
#(
  parameter int ADDR_WIDTH = 18,
  parameter int DIM_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  advance,
  input  logic [DIM_WIDTH-1:0]  src_w,
  input  logic [DIM_WIDTH-1:0]  src_h,
  input  logic [DIM_WIDTH-1:0]  dst_w,
  input  logic [DIM_WIDTH-1:0]  dst_h,
  input  logic [15:0]           step_x,
  input  logic [15:0]           step_y,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic [15:0]           x_int,
  output logic [15:0]           y_int,
  output logic [7:0]            x_frac,
  output logic [7:0]            y_frac,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last_col,
  output logic                  last_row
);

  localparam int PROD_W = 2 * DIM_WIDTH;

  logic [DIM_WIDTH-1:0] dst_x_q, dst_x_d;
  logic [DIM_WIDTH-1:0] dst_y_q, dst_y_d;
  logic [23:0]          acc_x_q, acc_x_d;
  logic [23:0]          acc_y_q, acc_y_d;
  logic [23:0]          clamped_x, clamped_y;
  logic [PROD_W-1:0]    row_off;

  assign last_col = (dst_x_q == dst_w - DIM_WIDTH'(1));
  assign last_row = (dst_y_q == dst_h - DIM_WIDTH'(1));

  // Raster step: x moves along the row, wrapping to the next row at the last column.
  always_comb begin
    dst_x_d = dst_x_q;
    dst_y_d = dst_y_q;
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    if (clear) begin
      dst_x_d = '0;
      dst_y_d = '0;
      acc_x_d = '0;
      acc_y_d = '0;
    end else if (advance) begin
      if (last_col) begin
        dst_x_d = '0;
        acc_x_d = '0;
        dst_y_d = dst_y_q + DIM_WIDTH'(1);
        acc_y_d = acc_add(acc_y_q, step_y);
      end else begin
        dst_x_d = dst_x_q + DIM_WIDTH'(1);
        acc_x_d = acc_add(acc_x_q, step_x);
      end
    end
  end

  // Counter and accumulator state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_x_q <= '0;
      dst_y_q <= '0;
      acc_x_q <= '0;
      acc_y_q <= '0;
    end else begin
      dst_x_q <= dst_x_d;
      dst_y_q <= dst_y_d;
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
    end
  end

  assign clamped_x = clamp_coord(acc_x_q, 16'(src_w));
  assign clamped_y = clamp_coord(acc_y_q, 16'(src_h));
  assign x_int     = clamped_x[23:FRAC_BITS];
  assign x_frac    = clamped_x[FRAC_BITS-1:0];
  assign y_int     = clamped_y[23:FRAC_BITS];
  assign y_frac    = clamped_y[FRAC_BITS-1:0];

  // Linear destination address; the sum wraps modulo the address space.
  assign row_off = PROD_W'(dst_y_q) * PROD_W'(dst_w);
  assign addr    = base_addr + ADDR_WIDTH'(row_off) + ADDR_WIDTH'(dst_x_q);

endmodule

// File: rtl/dsa_scan_controller.sv
// Sequential-mode frame scanner: one fetch per destination pixel, bundle handed to the interpolator.
// Latency: ISSUE->fetch_req 1 cycle; CAPTURE one cycle after fetch_valid; bundle valid the cycle after CAPTURE.
// Backpressure: waits for !fetch_busy before issuing; holds out_valid and the bundle stable until out_ready.
module dsa_scan_controller
  import dsa_pkg::*;
#(
  parameter int ADDR_WIDTH = 18,
  parameter int DIM_WIDTH  = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [DIM_WIDTH-1:0]   src_w,
  input  logic [DIM_WIDTH-1:0]   src_h,
  input  logic [DIM_WIDTH-1:0]   dst_w,
  input  logic [DIM_WIDTH-1:0]   dst_h,
  input  logic [15:0]            step_x,
  input  logic [15:0]            step_y,
  input  logic [ADDR_WIDTH-1:0]  dst_base_addr,
  output logic                   fetch_req,
  output logic [15:0]            fetch_x_int,
  output logic [15:0]            fetch_y_int,
  output logic [15:0]            fetch_frac_x,
  output logic [15:0]            fetch_frac_y,
  input  logic                   fetch_busy,
  input  logic                   fetch_valid,
  input  logic [7:0]             f_p00,
  input  logic [7:0]             f_p01,
  input  logic [7:0]             f_p10,
  input  logic [7:0]             f_p11,
  input  logic [15:0]            f_a,
  input  logic [15:0]            f_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_p00,
  output logic [7:0]             out_p01,
  output logic [7:0]             out_p10,
  output logic [7:0]             out_p11,
  output logic [15:0]            out_a,
  output logic [15:0]            out_b,
  output logic [ADDR_WIDTH-1:0]  out_addr,
  output logic                   busy,
  output logic                   done,
  output logic [2*DIM_WIDTH-1:0] pix_count
);

  localparam int PCW = 2 * DIM_WIDTH;

  scan_state_t           state_q;
  logic [DIM_WIDTH-1:0]  src_w_q, src_h_q, dst_w_q, dst_h_q;
  logic [15:0]           step_x_q, step_y_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  fetch_req_q, out_valid_q, done_q;
  logic [7:0]            p00_q, p01_q, p10_q, p11_q;
  logic [15:0]           a_q, b_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic [PCW-1:0]        pix_count_q;

  logic                  clear, advance;
  logic [7:0]            x_frac, y_frac;
  logic [ADDR_WIDTH-1:0] pix_addr;
  logic                  last_col, last_row;

  // Abort outranks everything, so neither counter update fires in an abort cycle.
  assign clear   = (state_q == IDLE) && start && !abort;
  assign advance = (state_q == EMIT) && out_ready && !abort;

  dsa_coord_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_coord (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .advance   (advance),
    .src_w     (src_w_q),
    .src_h     (src_h_q),
    .dst_w     (dst_w_q),
    .dst_h     (dst_h_q),
    .step_x    (step_x_q),
    .step_y    (step_y_q),
    .base_addr (base_q),
    .x_int     (fetch_x_int),
    .y_int     (fetch_y_int),
    .x_frac    (x_frac),
    .y_frac    (y_frac),
    .addr      (pix_addr),
    .last_col  (last_col),
    .last_row  (last_row)
  );

  // Frame sequencer with registered handshake outputs and latched configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_w_q     <= '0;
      src_h_q     <= '0;
      dst_w_q     <= '0;
      dst_h_q     <= '0;
      step_x_q    <= '0;
      step_y_q    <= '0;
      base_q      <= '0;
      fetch_req_q <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      p00_q       <= '0;
      p01_q       <= '0;
      p10_q       <= '0;
      p11_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_addr_q  <= '0;
      pix_count_q <= '0;
    end else begin
      fetch_req_q <= 1'b0;
      done_q      <= 1'b0;
      if (abort) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              src_w_q     <= src_w;
              src_h_q     <= src_h;
              dst_w_q     <= dst_w;
              dst_h_q     <= dst_h;
              step_x_q    <= step_x;
              step_y_q    <= step_y;
              base_q      <= dst_base_addr;
              pix_count_q <= '0;
              state_q     <= (dst_w == '0 || dst_h == '0) ? FINISH : ISSUE;
            end
          end
          ISSUE: begin
            if (!fetch_busy) begin
              fetch_req_q <= 1'b1;
              state_q     <= WAIT;
            end
          end
          WAIT: begin
            if (fetch_valid) state_q <= CAPTURE;
          end
          CAPTURE: begin
            // p11/a/b only settle on the edge that ends fetch_valid, hence one cycle late.
            p00_q       <= f_p00;
            p01_q       <= f_p01;
            p10_q       <= f_p10;
            p11_q       <= f_p11;
            a_q         <= f_a;
            b_q         <= f_b;
            out_addr_q  <= pix_addr;
            out_valid_q <= 1'b1;
            state_q     <= EMIT;
          end
          EMIT: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              pix_count_q <= pix_count_q + PCW'(1);
              state_q     <= (last_col && last_row) ? FINISH : ISSUE;
            end
          end
          FINISH: begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign fetch_req    = fetch_req_q;
  assign fetch_frac_x = {x_frac, 8'h00};
  assign fetch_frac_y = {y_frac, 8'h00};
  assign out_valid    = out_valid_q;
  assign out_p00      = p00_q;
  assign out_p01      = p01_q;
  assign out_p10      = p10_q;
  assign out_p11      = p11_q;
  assign out_a        = a_q;
  assign out_b        = b_q;
  assign out_addr     = out_addr_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign pix_count    = pix_count_q;

endmodule

// File: tb/tb_dsa_scan_controller.sv
// Randomized bench for dsa_scan_controller with a fetch-unit model and a frame-level reference model.
// Latency: n/a (testbench).
// Backpressure: out_ready randomized or forced low; fetch_busy randomized between requests.
module tb_dsa_scan_controller;

  localparam int AW = 18;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] src_w = '0, src_h = '0, dst_w = '0, dst_h = '0;
  logic [15:0]   step_x = '0, step_y = '0;
  logic [AW-1:0] dst_base_addr = '0;
  logic          fetch_req;
  logic [15:0]   fetch_x_int, fetch_y_int, fetch_frac_x, fetch_frac_y;
  logic          fetch_busy = 1'b0, fetch_valid = 1'b0;
  logic [7:0]    f_p00 = '0, f_p01 = '0, f_p10 = '0, f_p11 = '0;
  logic [15:0]   f_a = '0, f_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_p00, out_p01, out_p10, out_p11;
  logic [15:0]   out_a, out_b;
  logic [AW-1:0] out_addr;
  logic          busy, done;
  logic [2*DW-1:0] pix_count;

  dsa_scan_controller #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_w(src_w), .src_h(src_h), .dst_w(dst_w), .dst_h(dst_h),
    .step_x(step_x), .step_y(step_y), .dst_base_addr(dst_base_addr),
    .fetch_req(fetch_req), .fetch_x_int(fetch_x_int), .fetch_y_int(fetch_y_int),
    .fetch_frac_x(fetch_frac_x), .fetch_frac_y(fetch_frac_y),
    .fetch_busy(fetch_busy), .fetch_valid(fetch_valid),
    .f_p00(f_p00), .f_p01(f_p01), .f_p10(f_p10), .f_p11(f_p11), .f_a(f_a), .f_b(f_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p00(out_p00), .out_p01(out_p01), .out_p10(out_p10), .out_p11(out_p11),
    .out_a(out_a), .out_b(out_b), .out_addr(out_addr),
    .busy(busy), .done(done), .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard state.
  logic [63:0]   exp_req_q[$];
  logic [63:0]   data_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            beats = 0;
  int            done_cnt = 0;
  bit            fixed_data = 1'b0;
  bit            busy_knob = 1'b0;
  bit            force_low = 1'b0;

  // Fetch-unit model: fetch_valid 1..3 cycles after a request, data valid only the cycle after it.
  int          fm_phase = 0;
  int          fm_wait = 0;
  logic [63:0] fm_dat = '0;
  always begin
    @(posedge clk); #1;
    {f_p00, f_p01, f_p10, f_p11, f_a, f_b} = {$urandom, $urandom};
    fetch_valid = 1'b0;
    if (fm_phase == 2) begin
      {f_p00, f_p01, f_p10, f_p11, f_a, f_b} = fm_dat;
      fm_phase = 0;
    end else if (fm_phase == 1) begin
      if (fm_wait == 0) begin
        fetch_valid = 1'b1;
        fm_phase = 2;
      end else begin
        fm_wait--;
      end
    end
    if (fetch_req && rst_n) begin
      fm_dat   = fixed_data ? 64'h0a14_1e28_0080_0040 : {$urandom, $urandom};
      data_q.push_back(fm_dat);
      fm_phase = 1;
      fm_wait  = $urandom_range(0, 2);
    end
    fetch_busy = (fm_phase != 0) || (busy_knob && ($urandom_range(0, 3) == 0));
  end

  // Interpolator readiness.
  always begin
    @(posedge clk); #2;
    out_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: every request and every bundle cycle is checked against the model queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fetch_req) begin
        check("req_expected", exp_req_q.size() > 0, 1'b1);
        if (exp_req_q.size() > 0)
          check("req_coord", {fetch_x_int, fetch_y_int, fetch_frac_x, fetch_frac_y}, exp_req_q.pop_front());
      end
      if (out_valid) begin
        check("beat_expected", (data_q.size() > 0) && (exp_addr_q.size() > 0), 1'b1);
        if (data_q.size() > 0 && exp_addr_q.size() > 0) begin
          check("bundle", {out_p00, out_p01, out_p10, out_p11, out_a, out_b, out_addr},
                {data_q[0], exp_addr_q[0]});
          if (out_ready) begin
            check("pix_count", pix_count, beats);
            beats++;
            void'(data_q.pop_front());
            void'(exp_addr_q.pop_front());
          end
        end
      end
      if (done) done_cnt++;
    end
  end

  // Reference model: source position = index * step, clamped at the far edge.
  task automatic build_expected(input int sw, input int sh, input int dw, input int dh,
                                input int stx, input int sty, input int base);
    longint ax, ay, xi, yi, fx, fy;
    for (int y = 0; y < dh; y++) begin
      for (int x = 0; x < dw; x++) begin
        ax = longint'(x) * stx;
        ay = longint'(y) * sty;
        if (ax > 64'hFFFFFF) ax = 64'hFFFFFF;
        if (ay > 64'hFFFFFF) ay = 64'hFFFFFF;
        xi = ax / 256; fx = ax % 256;
        yi = ay / 256; fy = ay % 256;
        if (xi >= sw - 1) begin xi = sw - 2; fx = 255; end
        if (yi >= sh - 1) begin yi = sh - 2; fy = 255; end
        exp_req_q.push_back({16'(xi), 16'(yi), 8'(fx), 8'h00, 8'(fy), 8'h00});
        exp_addr_q.push_back(AW'(longint'(base) + longint'(y) * dw + x));
      end
    end
  endtask

  task automatic flush();
    repeat (8) @(posedge clk);
    #1;
    exp_req_q.delete();
    data_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic run_frame(input int sw, input int sh, input int dw, input int dh,
                           input int stx, input int sty, input int base,
                           input int stall_at, input int abort_at);
    int n, reqs;
    bit fin, stalled;
    src_w = DW'(sw); src_h = DW'(sh); dst_w = DW'(dw); dst_h = DW'(dh);
    step_x = 16'(stx); step_y = 16'(sty); dst_base_addr = AW'(base);
    exp_req_q.delete(); data_q.delete(); exp_addr_q.delete();
    build_expected(sw, sh, dw, dh, stx, sty, base);
    beats = 0; done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    // Configuration must have been latched: scramble the live inputs.
    src_w = DW'($urandom); src_h = DW'($urandom); dst_w = DW'($urandom); dst_h = DW'($urandom);
    step_x = 16'($urandom); step_y = 16'($urandom); dst_base_addr = AW'($urandom);
    n = 0; reqs = 0; fin = 1'b0; stalled = 1'b0;
    while (!fin && n < 4000) begin
      if (fetch_req) begin
        if (reqs == abort_at) begin
          abort = 1'b1; start = 1'b0;
          @(posedge clk); #1 abort = 1'b0;
          check("abort_busy", busy, 1'b0);
          repeat (6) @(posedge clk);
          #1;
          check("abort_done", done_cnt, 0);
          check("abort_pix", pix_count, abort_at);
          check("abort_vld", out_valid, 1'b0);
          flush();
          return;
        end
        reqs++;
      end
      if (stall_at >= 0 && !stalled && out_valid && beats == stall_at) begin
        start = 1'b0; force_low = 1'b1; stalled = 1'b1;
        for (int i = 0; i < 10; i++) begin
          check("stall_vld", out_valid, 1'b1);
          check("stall_req", fetch_req, 1'b0);
          check("stall_pix", pix_count, stall_at);
          @(posedge clk); #1;
          n++;
        end
        force_low = 1'b0;
      end
      if (done_cnt > 0) begin
        fin = 1'b1;
      end else begin
        start = busy && ($urandom_range(0, 15) == 0);
        @(posedge clk); #1;
        n++;
      end
    end
    start = 1'b0;
    check("frame_done", fin, 1'b1);
    if (!fin) begin
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      flush();
    end else begin
      repeat (2) @(posedge clk);
      #1;
      check("done_once", done_cnt, 1);
      check("pix_final", pix_count, dw * dh);
      check("queues_empty", exp_req_q.size() + data_q.size() + exp_addr_q.size(), 0);
      check("busy_end", busy, 1'b0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time budget exceeded, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {fetch_req, fetch_x_int, fetch_y_int, fetch_frac_x, fetch_frac_y,
                      out_valid, busy, done, pix_count}, '0);
    check("rst_bundle", {out_p00, out_p01, out_p10, out_p11, out_a, out_b, out_addr}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_busy", {busy, done, out_valid, fetch_req}, '0);

    // 4x4 -> 2x2, step 2.0, fixed fetch data 10/20/30/40, a=0x80, b=0x40.
    fixed_data = 1'b1;
    run_frame(4, 4, 2, 2, 'h200, 'h200, 0, -1, -1);
    fixed_data = 1'b0;

    // 4x4 -> 8x1, step 0.5: reaches the right edge and clamps to 2/FF.
    run_frame(4, 4, 8, 1, 'h80, 0, 0, -1, -1);

    // Interpolator stalls 10 cycles on the fifth beat.
    run_frame(5, 5, 3, 3, 'h100, 'h180, 'h100, 4, -1);

    // Abort while waiting on the third fetch, then a clean restart.
    run_frame(4, 4, 2, 2, 'h200, 'h200, 0, -1, 2);
    run_frame(4, 4, 2, 2, 'h200, 'h200, 0, -1, -1);

    // Empty frame: done two cycles after start, no fetch issued.
    src_w = 4; src_h = 4; dst_w = 0; dst_h = 3; done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("empty_d1", {busy, done}, 2'b10);
    @(posedge clk); #1;
    check("empty_done", done, 1'b1);
    @(posedge clk); #1;
    check("empty_end", {busy, done}, 2'b00);
    check("empty_pix", pix_count, 0);

    // start together with abort in IDLE is dropped.
    dst_w = 2; dst_h = 2;
    @(posedge clk); #1 begin start = 1'b1; abort = 1'b1; end
    @(posedge clk); #1 begin start = 1'b0; abort = 1'b0; end
    check("start_abort_idle", busy, 1'b0);
    @(posedge clk); #1;
    check("start_abort_idle2", {busy, fetch_req}, 2'b00);

    // Randomized frames with fetch_busy noise.
    busy_knob = 1'b1;
    for (int f = 0; f < 8; f++) begin
      run_frame($urandom_range(2, 40), $urandom_range(2, 40), $urandom_range(1, 7),
                $urandom_range(1, 5), $urandom_range(0, 'h600), $urandom_range(0, 'h600),
                $urandom_range(0, (1 << AW) - 1), -1, -1);
    end
    busy_knob = 1'b0;

    // Asynchronous reset in the middle of a frame.
    src_w = 6; src_h = 6; dst_w = 4; dst_h = 4; step_x = 'h140; step_y = 'h140; dst_base_addr = 100;
    exp_req_q.delete(); data_q.delete(); exp_addr_q.delete();
    build_expected(6, 6, 4, 4, 'h140, 'h140, 100);
    beats = 0; done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_ctl", {fetch_req, fetch_x_int, fetch_y_int, fetch_frac_x, fetch_frac_y,
                       out_valid, busy, done, pix_count}, '0);
    check("arst_bundle", {out_p00, out_p01, out_p10, out_p11, out_a, out_b, out_addr}, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    flush();
    run_frame(4, 4, 2, 2, 'h200, 'h200, 7, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
